ifetch_unit: RTL and testbench

Instruction fetch stage for the practice RV32I core. It sits directly upstream of the dual-port instruction/data RAM: it drives the RAM's port 1 address with the program counter and captures the combinationally returned 32-bit word. It then presents {pc, instruction} pairs to decode through a 2-entry buffered valid/ready interface. Branch/jump redirects from execute flush the buffer and restart fetch.

---
 rtl/ifetch_unit.sv | 109 ++++++++++
 tb/tb_ifetch_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// ifetch_unit: RV32I instruction fetch stage. Drives the PC onto RAM port 1,
// captures the combinational read word, and queues {pc, word} pairs for decode
// in a 2-entry buffer. Redirects flush the buffer and restart fetch.
module ifetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          MEM_BYTES = 4096
) (
   input  logic        m_clock,
   input  logic        p_reset,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        imem_we,
   output logic [31:0] imem_wdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   output logic        misalign,
   output logic [31:0] fetch_count
);

   // Address wrap mask; keeps the RAM's +3 byte read inside the array.
   localparam logic [31:0] AMASK = 32'(MEM_BYTES - 1);

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q;
   logic [31:0] e0_pc_q, e0_w_q, e1_pc_q, e1_w_q;
   logic        misalign_q;
   logic [31:0] fcnt_q;
   logic        pop, push;

   // A push is always possible unless the buffer is full and nothing leaves.
   assign pop  = inst_valid & inst_ready;
   assign push = ~redirect & ((state_q != FULL) | pop);

   // Occupancy state register.
   always_ff @(posedge m_clock or negedge p_reset) begin
      if (!p_reset) state_q <= EMPTY;
      else          state_q <= state_d;
   end

   // Next occupancy; redirect empties the buffer regardless of push/pop.
   always_comb begin
      state_d = state_q;
      if (redirect) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY:   if (push) state_d = ONE;
            ONE:     if (push && !pop) state_d = FULL;
            FULL:    state_d = FULL;
            default: state_d = EMPTY;
         endcase
      end
   end

   // Decode-side outputs from occupancy and the head entry.
   always_comb begin
      inst_valid = (state_q != EMPTY);
      inst       = e0_w_q;
      inst_pc    = e0_pc_q;
   end

   // PC, buffer entries, misalign pulse and push counter.
   always_ff @(posedge m_clock or negedge p_reset) begin
      if (!p_reset) begin
         pc_q       <= RESET_PC;
         e0_pc_q    <= '0;
         e0_w_q     <= '0;
         e1_pc_q    <= '0;
         e1_w_q     <= '0;
         misalign_q <= 1'b0;
         fcnt_q     <= '0;
      end else begin
         misalign_q <= 1'b0;
         if (redirect) begin
            pc_q       <= redirect_pc & AMASK & ~32'd3;
            misalign_q <= |redirect_pc[1:0];
         end else if (push) begin
            pc_q   <= (pc_q + 32'd4) & AMASK;
            fcnt_q <= fcnt_q + 32'd1;
            if (state_q == FULL) begin
               // FULL only pushes when popping: shift e1 up, new word behind it.
               e0_pc_q <= e1_pc_q;
               e0_w_q  <= e1_w_q;
               e1_pc_q <= pc_q;
               e1_w_q  <= imem_rdata;
            end else if (state_q == EMPTY || pop) begin
               e0_pc_q <= pc_q;
               e0_w_q  <= imem_rdata;
            end else begin
               e1_pc_q <= pc_q;
               e1_w_q  <= imem_rdata;
            end
         end
      end
   end

   assign imem_addr   = pc_q;
   assign imem_we     = 1'b0;
   assign imem_wdata  = '0;
   assign misalign    = misalign_q;
   assign fetch_count = fcnt_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: table-driven check of the fetch stage against hand-derived
// cycle-by-cycle expectations, plus directed async-reset sequences.
module tb_ifetch_unit;

   logic        m_clock = 1'b0;
   logic        p_reset = 1'b0;
   logic [31:0] imem_addr, imem_rdata, imem_wdata;
   logic        imem_we;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        inst_valid, inst_ready = 1'b0, misalign;
   logic [31:0] inst, inst_pc, fetch_count;

   int checks = 0;
   int failures = 0;

   ifetch_unit #(.RESET_PC(32'h0), .MEM_BYTES(4096)) dut (
      .m_clock(m_clock), .p_reset(p_reset),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .imem_we(imem_we), .imem_wdata(imem_wdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
      .inst_ready(inst_ready), .misalign(misalign),
      .fetch_count(fetch_count)
   );

   always #5 m_clock = ~m_clock;

   // RAM image: word at byte address a is 0x13 + (a/4)*0x80 (0x13, 0x93, 0x113...).
   function automatic logic [31:0] wd(input logic [31:0] a);
      return 32'h13 + (a >> 2) * 32'h80;
   endfunction

   assign imem_rdata = wd(imem_addr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Inputs applied for one cycle, and outputs expected just after that edge.
   typedef struct {
      logic        rd;
      logic [31:0] rpc;
      logic        rdy;
      logic        ev;
      logic [31:0] epc;
      logic [31:0] eaddr;
      logic        emis;
      logic [31:0] efc;
   } vec_t;

   vec_t vt[27];

   initial begin
      //            rd  rpc           rdy ev  epc          eaddr        mis fc
      vt[0]  = '{1'b0, 32'h0,       1'b1, 1'b1, 32'h000, 32'h004, 1'b0, 32'd1};
      vt[1]  = '{1'b0, 32'h0,       1'b1, 1'b1, 32'h004, 32'h008, 1'b0, 32'd2};
      vt[2]  = '{1'b0, 32'h0,       1'b1, 1'b1, 32'h008, 32'h00C, 1'b0, 32'd3};
      vt[3]  = '{1'b0, 32'h0,       1'b0, 1'b1, 32'h008, 32'h010, 1'b0, 32'd4};
      vt[4]  = '{1'b0, 32'h0,       1'b0, 1'b1, 32'h008, 32'h010, 1'b0, 32'd4};
      vt[5]  = '{1'b0, 32'h0,       1'b0, 1'b1, 32'h008, 32'h010, 1'b0, 32'd4};
      vt[6]  = '{1'b0, 32'h0,       1'b0, 1'b1, 32'h008, 32'h010, 1'b0, 32'd4};
      vt[7]  = '{1'b0, 32'h0,       1'b1, 1'b1, 32'h00C, 32'h014, 1'b0, 32'd5};
      vt[8]  = '{1'b0, 32'h0,       1'b1, 1'b1, 32'h010, 32'h018, 1'b0, 32'd6};
      vt[9]  = '{1'b1, 32'h100,     1'b0, 1'b0, 32'h000, 32'h100, 1'b0, 32'd6};
      vt[10] = '{1'b0, 32'h0,       1'b1, 1'b1, 32'h100, 32'h104, 1'b0, 32'd7};
      vt[11] = '{1'b0, 32'h0,       1'b1, 1'b1, 32'h104, 32'h108, 1'b0, 32'd8};
      vt[12] = '{1'b1, 32'h206,     1'b1, 1'b0, 32'h000, 32'h204, 1'b1, 32'd8};
      vt[13] = '{1'b0, 32'h0,       1'b1, 1'b1, 32'h204, 32'h208, 1'b0, 32'd9};
      vt[14] = '{1'b0, 32'h0,       1'b1, 1'b1, 32'h208, 32'h20C, 1'b0, 32'd10};
      vt[15] = '{1'b1, 32'hFF8,     1'b1, 1'b0, 32'h000, 32'hFF8, 1'b0, 32'd10};
      vt[16] = '{1'b0, 32'h0,       1'b1, 1'b1, 32'hFF8, 32'hFFC, 1'b0, 32'd11};
      vt[17] = '{1'b0, 32'h0,       1'b1, 1'b1, 32'hFFC, 32'h000, 1'b0, 32'd12};
      vt[18] = '{1'b0, 32'h0,       1'b1, 1'b1, 32'h000, 32'h004, 1'b0, 32'd13};
      vt[19] = '{1'b1, 32'h300,     1'b0, 1'b0, 32'h000, 32'h300, 1'b0, 32'd13};
      vt[20] = '{1'b1, 32'h400,     1'b0, 1'b0, 32'h000, 32'h400, 1'b0, 32'd13};
      vt[21] = '{1'b0, 32'h0,       1'b0, 1'b1, 32'h400, 32'h404, 1'b0, 32'd14};
      vt[22] = '{1'b0, 32'h0,       1'b0, 1'b1, 32'h400, 32'h408, 1'b0, 32'd15};
      vt[23] = '{1'b0, 32'h0,       1'b0, 1'b1, 32'h400, 32'h408, 1'b0, 32'd15};
      vt[24] = '{1'b1, 32'h1235,    1'b0, 1'b0, 32'h000, 32'h234, 1'b1, 32'd15};
      vt[25] = '{1'b0, 32'h0,       1'b0, 1'b1, 32'h234, 32'h238, 1'b0, 32'd16};
      vt[26] = '{1'b0, 32'h0,       1'b0, 1'b1, 32'h234, 32'h23C, 1'b0, 32'd17};

      // Reset state, checked before any clock edge.
      #2;
      chk("rst_valid", 32'(inst_valid), 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_mis", 32'(misalign), 32'd0);
      chk("rst_fc", fetch_count, 32'd0);
      chk("rst_inst", inst, 32'h0);
      chk("rst_pc", inst_pc, 32'h0);
      chk("we", 32'(imem_we), 32'd0);
      chk("wdata", imem_wdata, 32'h0);

      // Release between edges, then run the table one cycle per entry.
      @(negedge m_clock);
      p_reset = 1'b1;
      for (int i = 0; i < 27; i++) begin
         redirect    = vt[i].rd;
         redirect_pc = vt[i].rpc;
         inst_ready  = vt[i].rdy;
         @(posedge m_clock);
         #1;
         chk($sformatf("v%0d_valid", i), 32'(inst_valid), 32'(vt[i].ev));
         chk($sformatf("v%0d_addr", i), imem_addr, vt[i].eaddr);
         chk($sformatf("v%0d_mis", i), 32'(misalign), 32'(vt[i].emis));
         chk($sformatf("v%0d_fc", i), fetch_count, vt[i].efc);
         if (vt[i].ev) begin
            chk($sformatf("v%0d_ipc", i), inst_pc, vt[i].epc);
            chk($sformatf("v%0d_inst", i), inst, wd(vt[i].epc));
         end
         @(negedge m_clock);
      end

      // Async reset while FULL: outputs drop before any clock edge.
      redirect = 1'b0;
      inst_ready = 1'b0;
      #2;
      p_reset = 1'b0;
      #1;
      chk("ar_valid", 32'(inst_valid), 32'd0);
      chk("ar_addr", imem_addr, 32'h0);
      chk("ar_fc", fetch_count, 32'd0);
      chk("ar_ipc", inst_pc, 32'h0);

      // Held reset ignores clocks; release resumes at RESET_PC after one edge.
      @(posedge m_clock);
      #1;
      chk("ar_hold_valid", 32'(inst_valid), 32'd0);
      @(negedge m_clock);
      p_reset = 1'b1;
      inst_ready = 1'b1;
      @(posedge m_clock);
      #1;
      chk("rel_valid", 32'(inst_valid), 32'd1);
      chk("rel_ipc", inst_pc, 32'h0);
      chk("rel_inst", inst, 32'h13);
      chk("rel_fc", fetch_count, 32'd1);
      chk("rel_addr", imem_addr, 32'h4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
